// File: rtl/aes_out_serializer_pkg.sv
// Shared definitions for the AES output stage: block geometry and the
// serializer state encoding.
package aes_out_serializer_pkg;

  localparam int BLK_S         = 128;
  localparam int OUT_BUS_WORDS = 4;
  localparam int WORD_CNT_W    = $clog2(OUT_BUS_WORDS);

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

  function automatic logic is_last_word(input logic [WORD_CNT_W-1:0] cnt);
    return cnt == WORD_CNT_W'(OUT_BUS_WORDS - 1);
  endfunction

endpackage

// File: rtl/aes_out_serializer_blk_fifo.sv
// Synchronous block FIFO with extended-pointer full/empty detection and a
// programmable almost-full threshold.
module aes_blk_fifo #(
  parameter int WIDTH     = 129,
  parameter int ADDR_W    = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic [ADDR_W:0]   count_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W + 1)'(DEPTH - AF_MARGIN);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // A full FIFO refuses writes even when a read frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o        = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                         (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty_o       = (wr_ptr_q == rd_ptr_q);
  assign count_o       = wr_ptr_q - rd_ptr_q;
  assign almost_full_o = (count_o >= AF_LEVEL);
  assign data_o        = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/aes_out_serializer.sv
// AES output stage: buffers 128-bit result blocks and streams each one as
// four 32-bit words (most significant first) on an AXI4-Stream master.
module aes_out_serializer
  import aes_out_serializer_pkg::*;
#(
  parameter int BLK_WIDTH          = BLK_S,
  parameter int BUS_WIDTH          = 32,
  parameter int FIFO_ADDR_WIDTH    = 4,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [BLK_WIDTH-1:0] s_tdata,
  input  logic                 s_last,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 fifo_almost_full,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [BUS_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tlast
);

  localparam int ENTRY_W = BLK_WIDTH + 1;

  logic                     fifo_push, fifo_pop;
  logic [ENTRY_W-1:0]       fifo_head;
  logic                     head_full, head_empty, head_afull;
  logic [FIFO_ADDR_WIDTH:0] blk_count;

  ser_state_e               state_q, state_d;
  logic [WORD_CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [BLK_WIDTH-1:0]     blk_q, blk_d;
  logic                     blk_last_q, blk_last_d;
  logic                     word_hs;

  function automatic logic [BUS_WIDTH-1:0] word_sel(input logic [BLK_WIDTH-1:0]  blk,
                                                    input logic [WORD_CNT_W-1:0] idx);
    return blk[BLK_WIDTH - 1 - BUS_WIDTH * int'(idx) -: BUS_WIDTH];
  endfunction

  // Write side: the processing_done flag travels with its block.
  assign s_tready  = !head_full;
  assign fifo_push = s_tvalid && s_tready;

  aes_blk_fifo #(
    .WIDTH     (ENTRY_W),
    .ADDR_W    (FIFO_ADDR_WIDTH),
    .AF_MARGIN (ALMOST_FULL_MARGIN)
  ) u_blk_fifo (
    .clk           (clk),
    .reset         (reset),
    .push_i        (fifo_push),
    .data_i        ({s_last, s_tdata}),
    .pop_i         (fifo_pop),
    .data_o        (fifo_head),
    .full_o        (head_full),
    .empty_o       (head_empty),
    .almost_full_o (head_afull),
    .count_o       (blk_count)
  );

  assign fifo_full        = head_full;
  assign fifo_almost_full = head_afull;
  // Stay non-empty until the block in the serializer has fully drained.
  assign fifo_empty       = (blk_count == '0) && (state_q == SER_IDLE);

  // Stream side
  assign m_axis_tvalid = (state_q == SER_SEND);
  assign m_axis_tdata  = word_sel(blk_q, word_cnt_q);
  assign m_axis_tlast  = m_axis_tvalid && is_last_word(word_cnt_q) && blk_last_q;
  assign word_hs       = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    blk_d      = blk_q;
    blk_last_d = blk_last_q;
    fifo_pop   = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (!head_empty) begin
          fifo_pop                = 1'b1;
          {blk_last_d, blk_d}     = fifo_head;
          word_cnt_d              = '0;
          state_d                 = SER_SEND;
        end
      end
      SER_SEND: begin
        if (word_hs) begin
          if (is_last_word(word_cnt_q)) begin
            word_cnt_d = '0;
            // Chain straight into the next block so the stream has no bubble.
            if (!head_empty) begin
              fifo_pop            = 1'b1;
              {blk_last_d, blk_d} = fifo_head;
            end else begin
              state_d = SER_IDLE;
            end
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SER_IDLE;
      word_cnt_q <= '0;
      blk_q      <= '0;
      blk_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      blk_q      <= blk_d;
      blk_last_q <= blk_last_d;
    end
  end

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer: a block/word-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_aes_out_serializer;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_tvalid, s_tready, s_last;
  logic [127:0] s_tdata;
  logic         fifo_empty, fifo_full, fifo_almost_full;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [31:0]  m_axis_tdata;

  always #5 clk = ~clk;

  aes_out_serializer dut (
    .clk              (clk),
    .reset            (reset),
    .s_tvalid         (s_tvalid),
    .s_tready         (s_tready),
    .s_tdata          (s_tdata),
    .s_last           (s_last),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] gw(input int n, input int j);
    return {n[15:0], 16'hC0D0 + j[15:0]};
  endfunction

  function automatic logic [127:0] gblk(input int n);
    return {gw(n, 0), gw(n, 1), gw(n, 2), gw(n, 3)};
  endfunction

  // Reference model: a queue of stored blocks plus the words left to send.
  logic [128:0] mq[$];
  logic [128:0] m_cur = '0;
  int           m_cnt = 0;
  int           m_left = 0;
  bit           m_ok = 0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_cnt  = 0;
      m_left = 0;
      m_cur  = '0;
    end else begin
      bit hs, psh, pp;
      hs  = (m_left > 0) && m_axis_tready;
      psh = s_tvalid && (m_cnt < DEPTH);
      pp  = (m_cnt > 0) && ((m_left == 0) || (m_left == 1 && hs));
      if (hs) m_left--;
      if (psh) mq.push_back({s_last, s_tdata});
      if (pp) begin
        m_cur  = mq.pop_front();
        m_left = 4;
      end
      m_cnt = m_cnt + int'(psh) - int'(pp);
    end
    m_ok = 1;
  end

  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      int idx;
      chk("s_tready", s_tready, m_cnt != DEPTH);
      chk("fifo_full", fifo_full, m_cnt == DEPTH);
      chk("almost_full", fifo_almost_full, m_cnt >= DEPTH - 2);
      chk("fifo_empty", fifo_empty, (m_cnt == 0) && (m_left == 0));
      chk("tvalid", m_axis_tvalid, m_left > 0);
      if (m_left > 0) begin
        idx = 4 - m_left;
        chk("tdata", m_axis_tdata, m_cur[127 - 32*idx -: 32]);
        chk("tlast", m_axis_tlast, (m_left == 1) && m_cur[128]);
      end
    end
  end

  // Record of completed stream words and accepted blocks.
  logic [31:0] gd[$];
  bit          gl[$];
  int          gc[$];
  int          n_acc = 0;
  int          n_last = 0;
  int          cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      gd.push_back(m_axis_tdata);
      gl.push_back(m_axis_tlast);
      gc.push_back(cyc);
      if (m_axis_tlast) n_last++;
    end
    if (!reset && s_tvalid && s_tready) n_acc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int n, input int budget, input string nm);
    int k = 0;
    while (gd.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(nm, gd.size(), n);
  endtask

  task automatic chk_words(input int base, input int fb, input int nb, input string nm);
    for (int b = 0; b < nb; b++)
      for (int j = 0; j < 4; j++)
        chk(nm, gd[base + 4*b + j], gw(fb + b, j));
  endtask

  initial begin
    int base, b0, acc_e, k, lastc, nl;
    logic [15:0] pat;

    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_last = 1'b0; m_axis_tready = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_s_tready", s_tready, 1);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_afull", fifo_almost_full, 0);
    reset = 1'b0;
    tick();

    // Single block, MSW first, TLAST on the last word only
    base = gd.size();
    s_tvalid = 1'b1; s_tdata = 128'h00112233_44556677_8899AABB_CCDDEEFF; s_last = 1'b1;
    tick();
    acc_e = cyc;
    s_tvalid = 1'b0; s_last = 1'b0;
    wait_words(base + 4, 20, "t1_words");
    chk("t1_w0", gd[base],     32'h00112233);
    chk("t1_w1", gd[base + 1], 32'h44556677);
    chk("t1_w2", gd[base + 2], 32'h8899AABB);
    chk("t1_w3", gd[base + 3], 32'hCCDDEEFF);
    chk("t1_lasts", {gl[base], gl[base+1], gl[base+2], gl[base+3]}, 4'b0001);
    chk("t1_latency", gc[base], acc_e + 1);
    chk("t1_no_gap", gc[base + 3] - gc[base], 3);
    chk("t1_empty_after", fifo_empty, 1);

    // Three back-to-back blocks, processing_done only on the third
    base = gd.size(); b0 = n_acc; lastc = n_last;
    s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tdata = gblk(b0 + i);
      s_last  = (i == 2);
      tick();
    end
    s_tvalid = 1'b0; s_last = 1'b0;
    chk("t2_accepted", n_acc - b0, 3);
    wait_words(base + 12, 40, "t2_words");
    chk_words(base, b0, 3, "t2_data");
    chk("t2_no_bubble", gc[base + 11] - gc[base], 11);
    chk("t2_one_tlast", n_last - lastc, 1);
    chk("t2_tlast_pos", gl[base + 11], 1);

    // Ready toggling; data must be held through stalls
    tick();
    base = gd.size(); b0 = n_acc;
    pat = 16'b1001_1010_0110_1001;
    k = 0;
    while (gd.size() < base + 12 && k < 200) begin
      s_tvalid      = (n_acc - b0) < 3;
      s_tdata       = gblk(n_acc);
      s_last        = (n_acc - b0) == 2;
      m_axis_tready = pat[15 - (k % 16)];
      tick();
      k++;
    end
    s_tvalid = 1'b0; s_last = 1'b0; m_axis_tready = 1'b1;
    chk("t3_words", gd.size(), base + 12);
    chk_words(base, b0, 3, "t3_data");
    tick(); tick();

    // Fill with the stream stalled, then drain
    m_axis_tready = 1'b0; b0 = n_acc;
    for (int i = 0; i < 20; i++) begin
      s_tvalid = 1'b1; s_tdata = gblk(n_acc); s_last = 1'b0;
      tick();
      if (n_acc - b0 == 14) chk("t4_afull_at13", fifo_almost_full, 0);
      if (n_acc - b0 == 15) chk("t4_afull_at14", fifo_almost_full, 1);
    end
    s_tvalid = 1'b0;
    chk("t4_accepted", n_acc - b0, 17);
    chk("t4_full", fifo_full, 1);
    chk("t4_s_tready", s_tready, 0);
    base = gd.size();
    m_axis_tready = 1'b1;
    wait_words(base + 68, 120, "t4_words");
    chk_words(base, b0, 17, "t4_data");
    chk("t4_no_bubble", gc[base + 67] - gc[base], 67);
    tick(); tick();

    // Reset while word 2 of a block is on the bus
    base = gd.size();
    s_tvalid = 1'b1; s_tdata = gblk(n_acc); s_last = 1'b1;
    tick();
    s_tvalid = 1'b0; s_last = 1'b0;
    wait_words(base + 2, 20, "t5_pre");
    lastc = n_last;
    reset = 1'b1;
    tick();
    chk("t5_tvalid", m_axis_tvalid, 0);
    chk("t5_empty", fifo_empty, 1);
    chk("t5_tdata", m_axis_tdata, 0);
    chk("t5_tlast", m_axis_tlast, 0);
    reset = 1'b0;
    tick();
    chk("t5_no_tlast", n_last - lastc, 0);
    chk("t5_cut", gd.size(), base + 2);
    base = gd.size();
    s_tvalid = 1'b1; s_tdata = 128'h00112233_44556677_8899AABB_CCDDEEFF; s_last = 1'b1;
    tick();
    s_tvalid = 1'b0; s_last = 1'b0;
    wait_words(base + 4, 20, "t5_after");
    chk("t5_w0", gd[base],     32'h00112233);
    chk("t5_w3", gd[base + 3], 32'hCCDDEEFF);
    chk("t5_last", {gl[base], gl[base+3]}, 2'b01);
    tick(); tick();

    // Simultaneous push/pop at count 15 and at count 16
    m_axis_tready = 1'b0; b0 = n_acc; base = gd.size(); k = 0;
    while (n_acc - b0 < 17 && k < 30) begin
      s_tvalid = 1'b1; s_tdata = gblk(n_acc); s_last = n_acc[0];
      tick();
      k++;
    end
    s_tvalid = 1'b0; s_last = 1'b0;
    chk("t6_full", fifo_full, 1);
    m_axis_tready = 1'b1;
    wait_words(base + 7, 20, "t6_pre15");
    s_tvalid = 1'b1; s_tdata = gblk(n_acc);
    tick();
    chk("t6_acc15", n_acc - b0, 18);
    chk("t6_full15", fifo_full, 0);
    chk("t6_afull15", fifo_almost_full, 1);
    s_tdata = gblk(n_acc); m_axis_tready = 1'b0;
    tick();
    chk("t6_full16", fifo_full, 1);
    chk("t6_rdy16", s_tready, 0);
    s_tdata = gblk(n_acc); m_axis_tready = 1'b1;
    wait_words(base + 12, 20, "t6_pop16");
    s_tvalid = 1'b0;
    chk("t6_acc16", n_acc - b0, 19);
    chk("t6_full_after16", fifo_full, 0);
    chk("t6_rdy_after16", s_tready, 1);
    wait_words(base + 76, 150, "t6_drain");
    chk_words(base, b0, 19, "t6_data");

    k = 0;
    while (!fifo_empty && k < 50) begin
      tick();
      k++;
    end
    chk("final_empty", fifo_empty, 1);
    nl = n_last;
    tick(); tick();
    chk("final_quiet", n_last, nl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
